// File: rtl/truth_table_prober_pkg.sv
// truth_table_prober_pkg: shared state encoding, sizes and the row-to-bit mapping for the prober.
package truth_table_prober_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    localparam int ROWS   = 8;
    localparam int CODE_W = 8;
    // row 000 lands in the MSB so the code reads like the gate name (e.g. 0xD6)
    function automatic logic [2:0] row_to_bit(input logic [2:0] r);
        return 3'(ROWS - 1) - r;
    endfunction
endpackage

// File: rtl/probe_settle_timer.sv
// probe_settle_timer: loadable down-counter with a zero flag, paces how long each stimulus row is held.
module probe_settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/truth_table_prober.sv
// truth_table_prober: sweeps all 3-input rows into a gate and rebuilds its 8-bit truth-table code.
// Optional result comparison ports are added when TRUTH_TABLE_PROBER_CHECK_EN is defined.
module truth_table_prober
    import truth_table_prober_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_dut_out,
    output logic [2:0]        o_stim,
    output logic              o_busy,
    output logic              o_done,
    output logic [CODE_W-1:0] o_code
`ifdef TRUTH_TABLE_PROBER_CHECK_EN
    ,
    input  logic [CODE_W-1:0] i_expected,
    output logic              o_pass,
    output logic [CODE_W-1:0] o_mismatch
`endif
);
    state_t            r_state, w_next;
    logic [2:0]        r_row;
    logic [CODE_W-1:0] r_code, w_code_smp;
    logic              w_start, w_last, w_zero, w_reload;

    assign w_start  = (r_state == IDLE) && i_start;
    assign w_last   = (r_row == 3'(ROWS - 1));
    assign w_reload = w_start || (r_state == SAMPLE && !w_last);

    probe_settle_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_reload),
        .i_load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .i_dec      (r_state == SETTLE),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = SETTLE;
            SETTLE:  if (w_zero) w_next = SAMPLE;
            SAMPLE:  w_next = w_last ? DONE : SETTLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_code_smp = r_code;
        w_code_smp[row_to_bit(r_row)] = i_dut_out;
    end

    // the row register doubles as the stimulus, so it returns to 000 on the way into DONE
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_row  <= '0;
                r_code <= '0;
            end else if (r_state == SAMPLE) begin
                r_code <= w_code_smp;
                r_row  <= w_last ? 3'd0 : r_row + 3'd1;
            end
        end

    assign o_stim = r_row;
    assign o_busy = (r_state == SETTLE) || (r_state == SAMPLE);
    assign o_done = (r_state == DONE);
    assign o_code = r_code;

`ifdef TRUTH_TABLE_PROBER_CHECK_EN
    logic [CODE_W-1:0] r_expected, r_mismatch;
    logic              r_pass;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_expected <= '0;
            r_pass     <= 1'b0;
            r_mismatch <= '0;
        end else if (w_start) begin
            r_expected <= i_expected;
            r_pass     <= 1'b0;
            r_mismatch <= '0;
        end else if (r_state == SAMPLE && w_last) begin
            r_pass     <= (w_code_smp == r_expected);
            r_mismatch <= w_code_smp ^ r_expected;
        end
    assign o_pass     = r_pass;
    assign o_mismatch = r_mismatch;
`endif
endmodule

// File: tb/tb_truth_table_prober.sv
// tb_truth_table_prober: directed sweeps of modelled gates through two prober instances (4-cycle and 1-cycle settle).
module tb_truth_table_prober;
    logic       clk = 1'b0, rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0;
    logic [7:0] tt_a = 8'hD6, tt_b = 8'h96;
    logic [2:0] stim_a, stim_b;
    logic       busy_a, busy_b, done_a, done_b, dut_a, dut_b;
    logic [7:0] code_a, code_b;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;
    assign dut_a = tt_a[3'd7 - stim_a];
    assign dut_b = tt_b[3'd7 - stim_b];

`ifdef TRUTH_TABLE_PROBER_CHECK_EN
    logic [7:0] exp_a = 8'h00, mism_a, mism_b;
    logic       pass_a, pass_b;
`endif

    truth_table_prober #(.SETTLE_CYCLES(4), .CNT_W(8)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_dut_out(dut_a),
        .o_stim(stim_a), .o_busy(busy_a), .o_done(done_a), .o_code(code_a)
`ifdef TRUTH_TABLE_PROBER_CHECK_EN
        , .i_expected(exp_a), .o_pass(pass_a), .o_mismatch(mism_a)
`endif
    );

    truth_table_prober #(.SETTLE_CYCLES(1), .CNT_W(8)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_dut_out(dut_b),
        .o_stim(stim_b), .o_busy(busy_b), .o_done(done_b), .o_code(code_b)
`ifdef TRUTH_TABLE_PROBER_CHECK_EN
        , .i_expected(8'h96), .o_pass(pass_b), .o_mismatch(mism_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // n counts cycles after the start cycle; done is expected in cycle 8*(s+1)+1
    task automatic sweep(input bit sel, input int s, input logic [7:0] exp_code,
                         input int poke_at, input bit poke_rst);
        int         last;
        bit         aborted;
        logic [2:0] o_stim;
        logic       o_busy, o_done;
        logic [7:0] o_code;
        last    = 8 * (s + 1) + 1;
        aborted = 1'b0;
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        for (int n = 1; n <= last + 2; n++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (n == poke_at && !poke_rst) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            if (n == poke_at && poke_rst) begin
                rst_n = 1'b0;
                #1;
                o_code = sel ? code_b : code_a;
                chk("rst_stim", 32'(sel ? stim_b : stim_a), 0);
                chk("rst_busy", 32'(sel ? busy_b : busy_a), 0);
                chk("rst_done", 32'(sel ? done_b : done_a), 0);
                chk("rst_code", 32'(o_code), 0);
                rst_n   = 1'b1;
                aborted = 1'b1;
            end else begin
                o_stim = sel ? stim_b : stim_a;
                o_busy = sel ? busy_b : busy_a;
                o_done = sel ? done_b : done_a;
                o_code = sel ? code_b : code_a;
                chk("stim", 32'(o_stim), (!aborted && n < last) ? (n - 1) / (s + 1) : 0);
                chk("busy", 32'(o_busy), 32'(!aborted && n < last));
                chk("done", 32'(o_done), 32'(!aborted && n == last));
                if (n == 1) chk("code_clear", 32'(o_code), 0);
            end
        end
        o_code = sel ? code_b : code_a;
        chk(aborted ? "code_after_rst" : "code", 32'(o_code), aborted ? 0 : 32'(exp_code));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_stim", 32'(stim_a), 0);
        chk("reset_busy", 32'(busy_a), 0);
        chk("reset_done", 32'(done_a), 0);
        chk("reset_code", 32'(code_a), 0);
        chk("reset_code_b", 32'(code_b), 0);
        rst_n = 1'b1;

        tt_a = 8'hD6; sweep(1'b0, 4, 8'hD6, 0, 1'b0);
        tt_a = 8'h00; sweep(1'b0, 4, 8'h00, 0, 1'b0);
        tt_a = 8'hFF; sweep(1'b0, 4, 8'hFF, 0, 1'b0);
        tt_a = 8'hD6; sweep(1'b0, 4, 8'hD6, 10, 1'b0);
        sweep(1'b0, 4, 8'h00, 17, 1'b1);
        sweep(1'b0, 4, 8'hD6, 0, 1'b0);
        sweep(1'b1, 1, 8'h96, 0, 1'b0);

        // start held high: second sweep begins after exactly one IDLE cycle
        @(negedge clk);
        start_b = 1'b1;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            chk("b2b_done", 32'(done_b), 32'(n == 17 || n == 35));
            if (n == 18) chk("b2b_idle", 32'(busy_b), 0);
            if (n == 19) chk("b2b_busy", 32'(busy_b), 1);
            if (n == 35) start_b = 1'b0;
        end
        chk("b2b_code", 32'(code_b), 32'h96);

`ifdef TRUTH_TABLE_PROBER_CHECK_EN
        tt_a = 8'hD6; exp_a = 8'hD6;
        sweep(1'b0, 4, 8'hD6, 0, 1'b0);
        chk("pass_match", 32'(pass_a), 1);
        chk("mism_match", 32'(mism_a), 0);
        exp_a = 8'hD7;
        sweep(1'b0, 4, 8'hD6, 0, 1'b0);
        chk("pass_diff", 32'(pass_a), 0);
        chk("mism_diff", 32'(mism_a), 32'h01);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/truth_table_prober.md
Name: truth_table_prober

Overview:
- Sequential characterizer for 3-input combinational logic gates (the 0xNN truth-table family). It is the reading end of the gate interface: it drives every input combination into a device under test (DUT) and reconstructs that gate's 8-bit truth-table code.
- Sits in the verification/characterization harness beside the gate library. Its code output is compared directly against the gate's name, e.g. 0xD6.

Parameters:
- SETTLE_CYCLES, 4, cycles each input row is held before sampling; legal range 1..255.
- CNT_W, 8, width of the settle counter; must satisfy 2**CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- dut_out  input  1  output of the gate under test.
- stim  output  3  drives DUT inputs as {in1,in2,in3}.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when code is valid.
- code  output  8  captured truth table; held until the next accepted start.

Behaviour:
- Reset (asynchronous, active-low; applies at any time, including mid-sweep): state=IDLE, stim=3'b000, busy=0, done=0, code=8'h00, counter=0. The partial result is discarded; no done pulse is issued.
- Bit mapping: row r = {in1,in2,in3}; code[7-r] = dut_out sampled for row r. Row 000 maps to MSB and row 111 to LSB, so the 0xD6 gate yields 8'hD6.
- States:
  - IDLE: stim=000. On start=1, go to SETTLE; row=0; counter=SETTLE_CYCLES-1; code cleared to 00; busy=1 next cycle.
  - SETTLE: stim=row. Counter decrements each cycle. At 0, go to SAMPLE.
  - SAMPLE: code[7-row] <= dut_out at this edge.
    - If row==7, go to DONE.
    - Otherwise row increments (3-bit, no wrap used), counter reloads, and state returns to SETTLE.
  - DONE: done=1 for exactly one cycle, busy=0, stim=000, then IDLE.
- Timing:
  - Each row occupies SETTLE_CYCLES+1 cycles.
  - The done pulse asserts 8*(SETTLE_CYCLES+1)+1 cycles after the start edge.
  - stim changes only on clock edges and is registered (glitch-free).
- start while busy or in DONE: ignored, no queueing.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE (back-to-back sweeps, one IDLE cycle between).
- dut_out is sampled raw; it is assumed stable within SETTLE_CYCLES.

Optional Feature:
- Macro: TRUTH_TABLE_PROBER_CHECK_EN.
- When defined, adds the following ports:
  - expected (input, 8): expected code, sampled on accepted start.
  - pass (output, 1): registered with done; 1 iff code==expected.
  - mismatch (output, 8): code XOR expected, registered with done.
  - pass and mismatch reset to 0 and hold until the next accepted start.
- When undefined: the ports are absent, no comparison logic is present, and all other behaviour is identical.

Decomposition:
- Package truth_table_prober_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - ROWS=8;
  - CODE_W=8;
  - function row_to_bit(r) = 7-r.
- One natural sub-module, probe_settle_timer: loadable down-counter with a zero flag, parameterised by CNT_W. The FSM, row counter and code register stay in the top.

Test Plan:
- DUT model = 0xD6 gate, SETTLE_CYCLES=4, start pulse:
  - stim steps 000..111, 5 cycles each;
  - done pulses 41 cycles after start;
  - code=8'hD6;
  - busy low after.
- dut_out tied 0, then tied 1 (two sweeps) → code=8'h00, then code=8'hFF. The clear-on-start is visible because 00 appears before FF fills in.
- start re-pulsed at cycle 10 of a sweep → ignored; done still at cycle 41; code unchanged from the single-sweep value.
- rst_n low at cycle 17 mid-sweep → immediately stim=000, busy=0, code=00; no done pulse. A new start after release gives the correct code.
- SETTLE_CYCLES=1 with DUT = 0x96 (3-input XNOR in this bit order) → code=8'h96; done 17 cycles after start.
- CHECK_EN defined, DUT=0xD6:
  - expected=D6 → pass=1, mismatch=00.
  - expected=D7 → pass=0, mismatch=01.
